// File: rtl/latch_bank_arbiter.sv
// Round-robin write sequencer for a bank of level-sensitive latches: setup, gate-open and hold
// phases around every write, plus bank-wide clears that always win over pending writes.
module latch_bank_arbiter #(
  parameter  int DW       = 8,
  parameter  int AW       = 2,
  parameter  int OPEN_CYC = 2,
  localparam int NLAT     = 2**AW
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [3:0]        req,
  input  logic [4*AW-1:0]   wr_addr,
  input  logic [4*DW-1:0]   wr_data,
  input  logic              clr_req,
  output logic [3:0]        gnt,
  output logic [3:0]        ack,
  output logic              clr_ack,
  output logic              busy,
  output logic [DW-1:0]     lat_d,
  output logic [NLAT-1:0]   lat_en,
  output logic              lat_clr
);

  typedef enum logic [2:0] {INIT_CLR, IDLE, SETUP, OPEN, HOLD, CLEAR} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(OPEN_CYC - 1);

  state_t          state, state_nxt;
  logic [7:0]      cnt;
  logic [1:0]      ptr;
  logic [1:0]      win;
  logic [1:0]      rr_idx;
  logic            win_vld;
  logic [AW-1:0]   addr_q;

  // Descending scan so the requester closest to the pointer is the last one written, i.e. wins.
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    rr_idx  = ptr;
    for (int k = 3; k >= 0; k--) begin
      rr_idx = ptr + 2'(k);
      if (req[rr_idx]) begin
        win     = rr_idx;
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= INIT_CLR;
      cnt    <= CNT_LOAD;
      ptr    <= 2'd0;
      gnt    <= 4'd0;
      addr_q <= '0;
      lat_d  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        INIT_CLR, OPEN, CLEAR: if (cnt != 8'd0) cnt <= cnt - 8'd1;
        default:               cnt <= CNT_LOAD;
      endcase
      // Requester inputs are only ever sampled on the grant edge; later changes are ignored.
      if (state == IDLE && !clr_req && win_vld) begin
        gnt    <= 4'b0001 << win;
        ptr    <= win + 2'd1;
        addr_q <= wr_addr[win*AW +: AW];
        lat_d  <= wr_data[win*DW +: DW];
      end else if (state == HOLD) begin
        gnt <= 4'd0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT_CLR: if (cnt == 8'd0) state_nxt = IDLE;
      IDLE: begin
        if (clr_req)      state_nxt = CLEAR;
        else if (win_vld) state_nxt = SETUP;
      end
      SETUP:    state_nxt = OPEN;
      OPEN:     if (cnt == 8'd0) state_nxt = HOLD;
      HOLD:     state_nxt = IDLE;
      CLEAR:    if (cnt == 8'd0) state_nxt = IDLE;
      default:  state_nxt = INIT_CLR;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    ack     = 4'd0;
    clr_ack = 1'b0;
    lat_en  = '0;
    lat_clr = 1'b0;
    case (state)
      INIT_CLR: lat_clr = 1'b1;
      OPEN:     lat_en[addr_q] = 1'b1;
      HOLD:     ack = gnt;
      CLEAR: begin
        lat_clr = 1'b1;
        clr_ack = (cnt == 8'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Scoreboard bench for latch_bank_arbiter: expected writes/clears are queued when driven and
// retired against ack/clr_ack, with a behavioural latch-bank model fed by the bank outputs.
module tb_latch_bank_arbiter;

  localparam int DW       = 8;
  localparam int AW       = 2;
  localparam int NLAT     = 4;
  localparam int OPEN_CYC = 2;

  typedef struct {
    bit is_clr;
    int id;
    int addr;
    int data;
  } exp_t;

  logic              clk = 1'b0;
  logic              clr_n = 1'b1;
  logic [3:0]        req = '0;
  logic [4*AW-1:0]   wr_addr = '0;
  logic [4*DW-1:0]   wr_data = '0;
  logic              clr_req = 1'b0;
  logic [3:0]        gnt, ack;
  logic              clr_ack, busy, lat_clr;
  logic [DW-1:0]     lat_d;
  logic [NLAT-1:0]   lat_en;

  logic [3:0]        req_b = '0;
  logic [4*AW-1:0]   wr_addr_b = '0;
  logic [4*DW-1:0]   wr_data_b = '0;
  logic [3:0]        gnt_b, ack_b;
  logic              clr_ack_b, busy_b, lat_clr_b;
  logic [DW-1:0]     lat_d_b;
  logic [NLAT-1:0]   lat_en_b;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t            sb_q[$];
  int              grise_q[$];
  logic [DW-1:0]   lat_mem [NLAT];
  int              cyc = 0;
  int              en_len = 0;
  int              clr_len = 0;
  int              gnt_rise = 0;
  logic [3:0]      prev_gnt = '0;
  logic [NLAT-1:0] last_en = '0;

  always #5 clk = ~clk;

  latch_bank_arbiter #(.DW(DW), .AW(AW), .OPEN_CYC(OPEN_CYC)) u_dut (
    .clk(clk), .clr_n(clr_n), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .gnt(gnt), .ack(ack), .clr_ack(clr_ack), .busy(busy),
    .lat_d(lat_d), .lat_en(lat_en), .lat_clr(lat_clr)
  );

  latch_bank_arbiter #(.DW(DW), .AW(AW), .OPEN_CYC(1)) u_dut_b (
    .clk(clk), .clr_n(clr_n), .req(req_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .clr_req(1'b0), .gnt(gnt_b), .ack(ack_b), .clr_ack(clr_ack_b), .busy(busy_b),
    .lat_d(lat_d_b), .lat_en(lat_en_b), .lat_clr(lat_clr_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input int addr, input int data, input bit expect_ack);
    exp_t e;
    wr_addr[idx*AW +: AW] = AW'(addr);
    wr_data[idx*DW +: DW] = DW'(data);
    req[idx] = 1'b1;
    if (expect_ack) begin
      e.is_clr = 1'b0; e.id = idx; e.addr = addr; e.data = data;
      sb_q.push_back(e);
    end
  endtask

  task automatic waitGnt(input logic [3:0] exp_gnt);
    int n = 0;
    while (gnt == 4'd0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_after_reset", 32'(busy), 32'd0);
  endtask

  // Latch model plus per-cycle invariants; write/clear completions retire scoreboard entries.
  always @(negedge clk) begin
    exp_t e;
    logic any_set;
    if (lat_clr) begin
      for (int i = 0; i < NLAT; i++) lat_mem[i] = '0;
      clr_len++;
    end else begin
      clr_len = 0;
    end
    for (int i = 0; i < NLAT; i++) if (lat_en[i]) lat_mem[i] = lat_d;
    if (lat_en != '0) begin
      en_len++;
      last_en = lat_en;
    end
    if (gnt != 4'd0 && prev_gnt == 4'd0) begin
      gnt_rise = cyc;
      en_len   = 0;
      grise_q.push_back(cyc);
    end
    checkOutput("en_clr_excl", 32'((lat_en != '0) && lat_clr), 32'd0);
    checkOutput("en_outside_open", 32'((lat_en != '0) && (gnt == 4'd0 || ack != 4'd0)), 32'd0);
    checkOutput("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    checkOutput("b_en_clr_excl", 32'((lat_en_b != '0) && lat_clr_b), 32'd0);
    if (ack != 4'd0) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("ack_kind", 32'(e.is_clr), 32'd0);
        checkOutput("ack_id", 32'(ack), 32'(1 << e.id));
        checkOutput("gnt_held", 32'(gnt), 32'(1 << e.id));
        checkOutput("lat_d", 32'(lat_d), 32'(e.data));
        checkOutput("latch_mem", 32'(lat_mem[e.addr]), 32'(e.data));
        checkOutput("open_len", 32'(en_len), 32'(OPEN_CYC));
        checkOutput("en_addr", 32'(last_en), 32'(1 << e.addr));
        checkOutput("ack_latency", 32'(cyc - gnt_rise), 32'(1 + OPEN_CYC));
      end
    end
    if (clr_ack) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_clr_ack", 32'(clr_ack), 32'd0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("clr_kind", 32'(e.is_clr), 32'd1);
        checkOutput("clr_len", 32'(clr_len), 32'(OPEN_CYC));
        any_set = 1'b0;
        for (int i = 0; i < NLAT; i++) any_set |= (lat_mem[i] != '0);
        checkOutput("bank_cleared", 32'(any_set), 32'd0);
      end
    end
    prev_gnt = gnt;
    cyc++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   n;
    int   en_b;
    logic [NLAT-1:0] last_b;
    exp_t ce;

    // Reset then single write
    #1 clr_n = 1'b0;
    #1;
    checkOutput("rst_lat_clr", 32'(lat_clr), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_lat_en", 32'(lat_en), 32'd0);
    checkOutput("rst_lat_d", 32'(lat_d), 32'd0);
    checkOutput("rst_acks", 32'({ack, clr_ack}), 32'd0);
    repeat (3) @(posedge clk);
    #1 clr_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (lat_clr && n < 20) begin
      n++;
      @(negedge clk);
    end
    checkOutput("init_clr_len", 32'(n), 32'(OPEN_CYC));
    checkOutput("idle_busy", 32'(busy), 32'd0);
    tick();
    applyStimulus(0, 2, 'hA5, 1'b1);
    waitGnt(4'b0001);
    tick();
    req = '0;
    waitDrain(40);

    // Round-robin fairness from a fresh pointer
    tick();
    clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    waitIdle();
    tick();
    grise_q.delete();
    for (int i = 0; i < 4; i++) applyStimulus(i, i, 'h10 + i, 1'b1);
    applyStimulus(0, 0, 'h10, 1'b1);
    waitDrain(60);
    req = '0;
    checkOutput("rr_grants", 32'(grise_q.size()), 32'd5);
    for (int i = 1; i < grise_q.size(); i++)
      checkOutput("rr_period", 32'(grise_q[i] - grise_q[i-1]), 32'(3 + OPEN_CYC));

    // Clear raised during a write beats a pending request
    tick();
    applyStimulus(1, 1, 'h77, 1'b1);
    waitGnt(4'b0010);
    tick();
    req[1]  = 1'b0;
    clr_req = 1'b1;
    ce.is_clr = 1'b1; ce.id = 0; ce.addr = 0; ce.data = 0;
    sb_q.push_back(ce);
    applyStimulus(2, 3, 'h5A, 1'b1);
    n = 0;
    while (!clr_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("clr_ack_seen", 32'(clr_ack), 32'd1);
    clr_req = 1'b0;
    waitGnt(4'b0100);
    tick();
    req = '0;
    waitDrain(40);

    // Inputs changing after the grant are ignored
    tick();
    applyStimulus(0, 1, 'h3C, 1'b1);
    waitGnt(4'b0001);
    tick();
    wr_data[0 +: DW] = 8'hFF;
    req[0] = 1'b0;
    waitDrain(40);
    tick();
    tick();
    checkOutput("held_lat_d", 32'(lat_d), 32'h3C);
    checkOutput("held_mem", 32'(lat_mem[1]), 32'h3C);

    // Reset while the gate is open aborts the write and restores the pointer
    tick();
    applyStimulus(1, 2, 'h99, 1'b0);
    waitGnt(4'b0010);
    n = 0;
    while (lat_en == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_open_en", 32'(lat_en), 32'b0100);
    clr_n = 1'b0;
    req   = '0;
    #1;
    checkOutput("abort_lat_en", 32'(lat_en), 32'd0);
    checkOutput("abort_gnt", 32'(gnt), 32'd0);
    checkOutput("abort_ack", 32'(ack), 32'd0);
    checkOutput("abort_lat_clr", 32'(lat_clr), 32'd1);
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    waitIdle();
    checkOutput("abort_mem_cleared", 32'(lat_mem[2]), 32'd0);
    tick();
    applyStimulus(0, 3, 'hE1, 1'b1);
    applyStimulus(3, 1, 'h33, 1'b0);
    waitGnt(4'b0001);
    tick();
    req = '0;
    waitDrain(40);

    // Single-cycle gate build
    tick();
    wr_addr_b[2*AW +: AW] = 2'd1;
    wr_data_b[2*DW +: DW] = 8'hC3;
    req_b = 4'b0100;
    n = 0;
    while (gnt_b == 4'd0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("b_gnt", 32'(gnt_b), 32'b0100);
    tick();
    req_b  = '0;
    n      = 0;
    en_b   = 0;
    last_b = '0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (lat_en_b != '0) begin
        en_b++;
        last_b = lat_en_b;
      end
      if (ack_b != 4'd0) break;
    end
    checkOutput("b_open_len", 32'(en_b), 32'd1);
    checkOutput("b_en_addr", 32'(last_b), 32'b0010);
    checkOutput("b_ack", 32'(ack_b), 32'b0100);
    checkOutput("b_lat_d", 32'(lat_d_b), 32'hC3);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
